// File: rtl/dem_switch_tree.sv
// Tree-structured DEM encoder: splits a quantizer code across 2^LEVELS unit elements,
// one pipeline stage per tree level, with random or first-order-shaped node switching.
module dem_switch_tree #(
  parameter int          LEVELS = 3,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  input  logic [LEVELS:0]          x_i,
  input  logic                     mode_i,
  output logic                     valid_o,
  output logic [(1<<LEVELS)-1:0]   ue_o,
  output logic                     sat_o
);

  localparam int          N        = 1 << LEVELS;
  localparam int          W        = LEVELS + 1;
  localparam int          NODES    = N - 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [W-1:0] FULL    = W'(N);

  logic [15:0]         lfsr_q, lfsr_d;
  logic [W-1:0]        val_q [LEVELS+1][N];
  logic [W-1:0]        val_d [LEVELS+1][N];
  logic [LEVELS:0]     vld_q, sat_q;
  logic [LEVELS-1:0]   mode_q;
  logic [15:0]         pn_q  [LEVELS];
  logic signed [1:0]   acc_q [NODES];
  logic signed [1:0]   acc_d [NODES];

  logic [W-1:0]        nx;
  logic signed [W:0]   ns, sa, sb;
  logic                np;
  int                  nj;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Stage k evaluates the 2^(k-1) nodes of its level; node j's children land at 2i / 2i+1.
  always_comb begin
    val_d = val_q;
    acc_d = acc_q;
    nx    = '0;
    ns    = '0;
    sa    = '0;
    sb    = '0;
    np    = 1'b0;
    nj    = 0;
    val_d[0][0] = (x_i > FULL) ? FULL : x_i;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int i = 0; i < (1 << (k - 1)); i++) begin
        nj = (1 << (k - 1)) - 1 + i;
        nx = val_q[k-1][i];
        np = pn_q[k-1][nj[3:0]];
        ns = '0;
        if (nx[0]) begin
          if (!mode_q[k-1] || acc_q[nj] == 2'sd0) begin
            ns = np ? (W+1)'(1) : '1;
          end else begin
            ns = acc_q[nj][1] ? (W+1)'(1) : '1;
          end
          if (vld_q[k-1]) begin
            acc_d[nj] = (mode_q[k-1] && acc_q[nj] == 2'sd0) ? ns[1:0] : 2'sd0;
          end
        end
        sa = $signed({1'b0, nx}) + ns;
        sb = $signed({1'b0, nx}) - ns;
        val_d[k][2*i]   = sa[W:1];
        val_d[k][2*i+1] = sb[W:1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= SEED_EFF;
      vld_q  <= '0;
      sat_q  <= '0;
      mode_q <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        for (int i = 0; i < N; i++) begin
          val_q[k][i] <= '0;
        end
      end
      for (int k = 0; k < LEVELS; k++) begin
        pn_q[k] <= '0;
      end
      for (int j = 0; j < NODES; j++) begin
        acc_q[j] <= 2'sd0;
      end
    end else begin
      vld_q <= {vld_q[LEVELS-1:0], valid_i};
      if (valid_i) begin
        lfsr_q      <= lfsr_d;
        val_q[0][0] <= val_d[0][0];
        sat_q[0]    <= (x_i > FULL);
        pn_q[0]     <= lfsr_q;
        mode_q[0]   <= mode_i;
      end
      // Stages hold when empty so ue_o keeps its last pattern through bubbles.
      for (int k = 1; k <= LEVELS; k++) begin
        if (vld_q[k-1]) begin
          for (int i = 0; i < N; i++) begin
            val_q[k][i] <= val_d[k][i];
          end
          sat_q[k] <= sat_q[k-1];
        end
      end
      for (int k = 1; k < LEVELS; k++) begin
        if (vld_q[k-1]) begin
          pn_q[k]   <= pn_q[k-1];
          mode_q[k] <= mode_q[k-1];
        end
      end
      acc_q <= acc_d;
    end
  end

  assign valid_o = vld_q[LEVELS];
  assign sat_o   = sat_q[LEVELS];

  always_comb begin
    ue_o = '0;
    for (int i = 0; i < N; i++) begin
      ue_o[i] = val_q[LEVELS][i][0];
    end
  end

endmodule
